// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline types and constants for the front end
//
// Purpose: constants and types shared by the fetch unit and the IF/ID register.
//   XLEN          - datapath width
//   NOP_INSTR     - canonical NOP (addi x0,x0,0) used when no instruction is valid
//   fetch_state_t - fetch FSM states
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no request outstanding, issue one now
        WAIT = 2'd1,  // one request outstanding, response will be used
        HOLD = 2'd2,  // response captured, IF/ID stalled
        DROP = 2'd3   // one request outstanding, response is wrong-path
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage feeding the IF/ID register
//
// Purpose: owns the PC, issues single-word fetches (at most one outstanding),
// presents each returned instruction with its PC, holds it across stalls and
// discards wrong-path responses after a redirect.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   stall             - hazard stall (same signal stalls IF/ID)
//   redirect          - taken branch/jump from EX, flushes IF/ID
//   redirect_pc       - redirect target, low two bits ignored
//   imem_req          - single-cycle fetch request
//   imem_addr         - request address (the internal pc)
//   imem_rvalid       - fetch response valid
//   imem_rdata        - fetch response instruction
//   fetch_valid       - fetch_instr/fetch_pc carry a real instruction
//   fetch_instr       - instruction to IF/ID, NOP when not valid
//   fetch_pc          - PC of fetch_instr, 0 when not valid
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_instr,
    output logic [XLEN-1:0] fetch_pc
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic            issue;
    logic [XLEN-1:0] redirect_tgt;

    // Targets are always word aligned; the low bits from EX are discarded.
    assign redirect_tgt = redirect_pc & ~32'h0000_0003;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        hold_instr_d = hold_instr_q;
        issue        = 1'b0;
        fetch_valid  = 1'b0;
        fetch_instr  = NOP_INSTR;
        fetch_pc     = '0;

        if (reset) begin
            state_d      = IDLE;
            pc_d         = RESET_PC;
            req_pc_d     = RESET_PC;
            hold_instr_d = NOP_INSTR;
        end else if (redirect) begin
            pc_d         = redirect_tgt;
            hold_instr_d = NOP_INSTR;
            // A request still in flight must have its response swallowed;
            // if it returns this very cycle it is already gone.
            if ((state_q == WAIT || state_q == DROP) && !imem_rvalid) begin
                state_d = DROP;
            end else begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Stall does not block issue: the result is held in HOLD.
                    issue   = 1'b1;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        fetch_valid = 1'b1;
                        fetch_instr = imem_rdata;
                        fetch_pc    = req_pc_q;
                        if (!stall) begin
                            issue = 1'b1;
                        end else begin
                            hold_instr_d = imem_rdata;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    fetch_valid = 1'b1;
                    fetch_instr = hold_instr_q;
                    fetch_pc    = req_pc_q;
                    if (!stall) begin
                        issue   = 1'b1;
                        state_d = WAIT;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        issue   = 1'b1;
                        state_d = WAIT;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (issue) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        pc_q         <= pc_d;
        req_pc_q     <= req_pc_d;
        hold_instr_q <= hold_instr_d;
    end

    assign imem_req  = issue;
    // pc_q is not yet loaded in the first reset cycle, so show RESET_PC directly.
    assign imem_addr = reset ? RESET_PC : pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset, stall, redirect, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, fetch_valid;
    logic [31:0] imem_addr, fetch_instr, fetch_pc;

    logic        w_reset, w_stall, w_redirect, w_rvalid;
    logic [31:0] w_redirect_pc, w_rdata;
    logic        w_imem_req, w_fetch_valid;
    logic [31:0] w_imem_addr, w_fetch_instr, w_fetch_pc;

    int          n_assert = 0;
    int          n_fail   = 0;

    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          mem_lat;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_fetch_q[$];

    if_fetch_unit u_dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .reset(w_reset), .stall(w_stall), .redirect(w_redirect),
        .redirect_pc(w_redirect_pc), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .fetch_valid(w_fetch_valid), .fetch_instr(w_fetch_instr), .fetch_pc(w_fetch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs (memory model supplies the response), then settle.
    task automatic drive(input logic rst, input logic st, input logic rd, input logic [31:0] rpc);
        reset       = rst;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data(pend_addr);
                pend        = 1'b0;
            end
        end
        #3;
    endtask

    // Scoreboard the settled outputs, record any request, advance past the edge.
    task automatic adv();
        if (imem_req) begin
            if (exp_addr_q.size() == 0) chk("req_unexpected", 32'(imem_req), 32'd0);
            else chk("imem_addr", imem_addr, exp_addr_q.pop_front());
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = mem_lat;
        end
        if (fetch_valid) begin
            if (exp_fetch_q.size() == 0) chk("fetch_unexpected", 32'(fetch_valid), 32'd0);
            else begin
                chk("fetch_pc", fetch_pc, exp_fetch_q[0]);
                chk("fetch_instr", fetch_instr, mem_data(exp_fetch_q[0]));
                if (!stall) void'(exp_fetch_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        pend = 1'b0; pend_addr = '0; pend_cnt = 0; mem_lat = 1;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        w_reset = 1'b1; w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;
        w_rvalid = 1'b0; w_rdata = '0;
        @(posedge clk);
        #1;

        // reset state
        drive(1, 0, 0, 0);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_fetch_valid", 32'(fetch_valid), 0);
        chk("rst_fetch_instr", fetch_instr, NOP);
        chk("rst_fetch_pc", fetch_pc, 0);
        chk("wrap_rst_imem_addr", w_imem_addr, 32'hFFFF_FFFC);
        adv();
        drive(1, 0, 0, 0);
        chk("rst_fetch_valid2", 32'(fetch_valid), 0);
        adv();

        // streaming with 1-cycle memory, then a 3-cycle stall at pc 8
        exp_addr_q  = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_fetch_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        w_reset = 1'b0;
        drive(0, 0, 0, 0);                                   // A
        chk("first_req", 32'(imem_req), 1);
        chk("first_fetch_valid", 32'(fetch_valid), 0);
        chk("wrap_req", 32'(w_imem_req), 1);
        chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
        adv();
        w_rvalid = 1'b1; w_rdata = 32'h1234_5678;
        drive(0, 0, 0, 0);                                   // B
        chk("stream_valid_b", 32'(fetch_valid), 1);
        chk("wrap_fetch_valid", 32'(w_fetch_valid), 1);
        chk("wrap_fetch_pc", w_fetch_pc, 32'hFFFF_FFFC);
        chk("wrap_fetch_instr", w_fetch_instr, 32'h1234_5678);
        chk("wrap_addr1", w_imem_addr, 32'h0);
        chk("wrap_req1", 32'(w_imem_req), 1);
        chk("wrap_no_x", 32'($isunknown({w_imem_req, w_imem_addr, w_fetch_valid, w_fetch_instr, w_fetch_pc})), 0);
        adv();
        w_rvalid = 1'b0;
        drive(0, 0, 0, 0);                                   // C
        chk("stream_valid_c", 32'(fetch_valid), 1);
        adv();
        drive(0, 1, 0, 0);                                   // D: response 8 under stall
        chk("stall_req_d", 32'(imem_req), 0);
        chk("stall_valid_d", 32'(fetch_valid), 1);
        adv();
        for (int i = 0; i < 2; i++) begin                    // E, F: HOLD
            drive(0, 1, 0, 0);
            chk("hold_req", 32'(imem_req), 0);
            chk("hold_valid", 32'(fetch_valid), 1);
            chk("hold_pc", fetch_pc, 32'h8);
            adv();
        end
        drive(0, 0, 0, 0);                                   // G: release
        chk("release_req", 32'(imem_req), 1);
        chk("release_addr", imem_addr, 32'hC);
        chk("release_pc", fetch_pc, 32'h8);
        adv();

        // redirect while a slow request at 0x10 is outstanding
        exp_addr_q.push_back(32'h10);
        mem_lat = 3;
        drive(0, 0, 0, 0);                                   // H
        adv();
        mem_lat = 1;
        exp_addr_q.push_back(32'h100);
        exp_fetch_q.push_back(32'h100);
        drive(0, 0, 1, 32'h100);                             // I
        chk("redir_req", 32'(imem_req), 0);
        chk("redir_valid", 32'(fetch_valid), 0);
        adv();
        drive(0, 0, 0, 0);                                   // J
        chk("drop_req", 32'(imem_req), 0);
        adv();
        drive(0, 0, 0, 0);                                   // K: stale response
        chk("stale_valid", 32'(fetch_valid), 0);
        chk("stale_req", 32'(imem_req), 1);
        chk("stale_addr", imem_addr, 32'h100);
        adv();
        exp_addr_q.push_back(32'h104);
        drive(0, 0, 0, 0);                                   // L
        chk("target_valid", 32'(fetch_valid), 1);
        adv();

        // redirect + rvalid + stall together, unaligned target
        exp_addr_q.push_back(32'h200);
        exp_fetch_q.push_back(32'h200);
        drive(0, 1, 1, 32'h203);                             // M
        chk("combo_valid", 32'(fetch_valid), 0);
        chk("combo_req", 32'(imem_req), 0);
        adv();
        drive(0, 0, 0, 0);                                   // N
        chk("combo_next_req", 32'(imem_req), 1);
        chk("combo_next_addr", imem_addr, 32'h200);
        adv();

        // reset while in DROP, followed by a late response
        exp_addr_q.push_back(32'h204);
        mem_lat = 3;
        drive(0, 0, 0, 0);                                   // O
        adv();
        mem_lat = 1;
        drive(0, 0, 1, 32'h300);                             // P: enter DROP
        chk("drop2_req", 32'(imem_req), 0);
        adv();
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        exp_fetch_q.push_back(32'h0);
        exp_fetch_q.push_back(32'h4);
        drive(1, 0, 0, 0);                                   // Q: reset
        chk("rst2_req", 32'(imem_req), 0);
        chk("rst2_valid", 32'(fetch_valid), 0);
        adv();
        drive(0, 0, 0, 0);                                   // R: late response in IDLE
        chk("late_valid", 32'(fetch_valid), 0);
        chk("late_req", 32'(imem_req), 1);
        chk("late_addr", imem_addr, 32'h0);
        adv();
        drive(0, 0, 0, 0);                                   // S
        chk("post_rst_valid", 32'(fetch_valid), 1);
        adv();
        drive(0, 0, 0, 0);                                   // T
        adv();

        chk("addr_q_left", 32'(exp_addr_q.size()), 0);
        chk("fetch_q_left", 32'(exp_fetch_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that drives the IF/ID pipeline register. It owns the program counter and issues word requests to instruction memory, with at most one request outstanding. It presents each returned instruction with its PC to IF/ID, holds it across hazard stalls, and discards wrong-path responses after a branch/jump redirect from EX.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall  in  1  hazard stall; the same signal drives IF/ID
- redirect  in  1  taken branch/jump from EX; also flushes IF/ID
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0
- imem_req  out  1  single-cycle fetch request
- imem_addr  out  32  request address; equals the internal pc
- imem_rvalid  in  1  response valid; arrives at least 1 cycle after its request
- imem_rdata  in  32  response instruction
- fetch_valid  out  1  fetch_instr/fetch_pc carry a real instruction
- fetch_instr  out  32  instruction to IF/ID; NOP (32'h00000013) when fetch_valid=0
- fetch_pc  out  32  PC of fetch_instr; 0 when fetch_valid=0

## Operation
- Registers:
  - pc: next address to request.
  - req_pc: address of the outstanding or held instruction.
  - hold_instr
  - state ∈ {IDLE, WAIT, HOLD, DROP}.
- Issue: imem_req=1 sets req_pc<=pc and pc<=pc+4. Arithmetic is mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- Priority: reset > redirect > stall.
- Redirect, any state:
  - pc<=redirect_pc, with bits [1:0] cleared.
  - imem_req=0 and fetch_valid=0 that cycle; hold buffer discarded.
  - Next state: DROP if in WAIT/DROP with no imem_rvalid that cycle, else IDLE.
- IDLE: imem_req=1, then go to WAIT. stall does not block the issue.
- WAIT, imem_rvalid=0: no action.
- WAIT, imem_rvalid=1:
  - fetch_valid=1, fetch_instr=imem_rdata, fetch_pc=req_pc.
  - If ~stall: the instruction is consumed; issue the next request the same cycle and stay in WAIT.
  - If stall: hold_instr<=imem_rdata and go to HOLD.
- HOLD:
  - fetch_valid=1, fetch_instr=hold_instr, fetch_pc=req_pc.
  - If ~stall: consumed; issue the next request and go to WAIT.
  - If stall: remain in HOLD.
- DROP:
  - fetch_valid=0.
  - On imem_rvalid: discard the response, issue a request at pc, and go to WAIT.
- fetch_* outputs are combinational from state and response; IF/ID registers them.

## Timing
- Reset values:
  - Registers: pc=RESET_PC, state=IDLE.
  - Outputs during reset: imem_req=0, imem_addr=RESET_PC, fetch_valid=0, fetch_instr=NOP, fetch_pc=0.
- First imem_req occurs in the first cycle with reset=0, with addr RESET_PC.
- Latency:
  - A response is visible on fetch_* in the same cycle as imem_rvalid.
  - With 1-cycle memory and no stalls, throughput is 1 instruction/cycle.
- Redirect at cycle t with no request outstanding: imem_req with addr redirect_pc at t+1.
- Redirect at cycle t while a request is outstanding: redirect_pc is requested in the cycle the stale imem_rvalid arrives.
- Simultaneous redirect+imem_rvalid in WAIT: the response is dropped; the request goes out next cycle (from IDLE).
- Second redirect while in DROP: pc is replaced by the newer target and the state stays DROP.
- Simultaneous redirect+stall: redirect wins.
- Reset mid-operation (any state): return to IDLE. A late imem_rvalid while in IDLE is ignored. The memory is reset together with this block.
- Never more than one request outstanding. imem_req is never asserted in WAIT without imem_rvalid, or in HOLD with stall.

## Structure
- Shared package riscv_pkg:
  - NOP_INSTR = 32'h00000013, shared with IF/ID.
  - fetch_state_t enum {IDLE, WAIT, HOLD, DROP}.
  - XLEN = 32.
- No sub-module: one FSM plus the pc, req_pc and hold datapath registers.

## Test plan
- Reset release, 1-cycle memory returning addr-derived data:
  - Required: imem_addr sequence 0,4,8,C.
  - Required: fetch_valid=1 every cycle from the first response, with fetch_pc matching each address.
- stall held 3 cycles during a response at pc 8:
  - Required: HOLD keeps fetch_instr/fetch_pc=8 stable, with no imem_req.
  - Required: on stall release, the instruction is consumed and imem_addr=C is issued the same cycle.
- Redirect to 32'h100 while a 3-cycle-latency request at 0x10 is outstanding:
  - Required: the 0x10 response yields fetch_valid=0.
  - Required: imem_addr=32'h100 is issued in the same cycle as that response.
- redirect_pc=32'h203 simultaneous with imem_rvalid and stall:
  - Required: fetch_valid=0 and imem_req=0 that cycle.
  - Required: next cycle imem_addr=32'h200.
- RESET_PC=32'hFFFF_FFFC: the second request address is 0, with no X on any output.
- Reset asserted in DROP, then a late imem_rvalid:
  - Required: the response is ignored and fetch_valid stays 0.
  - Required: the first post-reset request is at RESET_PC.
